trng_arbiter: RTL

TRNG_ARBITER -- requirements
Module: trng_arbiter

---
 rtl/trng_pkg.sv | 24 ++
 rtl/trng_rr_arb.sv | 35 +++
 rtl/trng_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG word arbiter: FSM states, default
// geometry, requester count and a one-hot helper.
package trng_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 32;
  localparam int unsigned DEFAULT_RCT_CUTOFF = 16;
  localparam int unsigned NUM_REQ            = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2,
    FAIL    = 2'd3
  } state_t;

  // One-hot requester mask from a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic idx);
    logic [NUM_REQ-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/trng_rr_arb.sv
// Two-way round-robin arbiter. The requester matching the priority
// pointer wins a tie, a lone requester always wins. On advance the
// pointer moves to the requester that was not the current grant.
module trng_rr_arb
  import trng_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic               grant
);

  logic ptr;

  // Combinational pick: pointer first, then the other requester.
  always_comb begin
    grant = ptr;
    if (req[ptr]) begin
      grant = ptr;
    end else if (req[~ptr]) begin
      grant = ~ptr;
    end
  end

  // Priority pointer, handed to the non-served requester on advance.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~grant;
    end
  end

endmodule

// File: rtl/trng_arbiter.sv
// TRNG word arbiter: serves 2 requesters round-robin, collecting WIDTH
// serial entropy bits MSB-first per served word.
// Optional repetition-count health test: define TRNG_ARBITER_HEALTH_EN.
//
// Handshake: req_valid[i] is a level held until served; req_ready[i]
// is a one-cycle pulse during which rdata carries the word. Dropping
// the granted req_valid during collection aborts the word silently.
module trng_arbiter
  import trng_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int RCT_CUTOFF = DEFAULT_RCT_CUTOFF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [WIDTH-1:0]   rdata,
  input  logic               trng_bit,
  output logic               trng_req,
  output logic               health_fail
);

  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > 32 || RCT_CUTOFF < 1) begin : g_bad_param
    $error("trng_arbiter: illegal WIDTH or RCT_CUTOFF");
  end

  state_t             state;
  state_t             state_nxt;
  logic               grant_q;
  logic               arb_grant;
  logic [NUM_REQ-1:0] arb_req;
  logic               arb_advance;
  logic [WIDTH-1:0]   word;
  logic [CW-1:0]      cnt;
  logic               granted_valid;
  logic               last_sample;
  logic               health_trip;

  assign granted_valid = req_valid[grant_q];
  assign last_sample   = (cnt == CW'(WIDTH - 1));

  // During DONE the arbiter sees only the served requester, so its grant
  // equals the served index and the pointer moves to the other one.
  assign arb_req     = (state == DONE) ? onehot(grant_q) : req_valid;
  assign arb_advance = (state == DONE);

  trng_rr_arb u_rr_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req     (arb_req),
    .advance (arb_advance),
    .grant   (arb_grant)
  );

`ifdef TRNG_ARBITER_HEALTH_EN
  localparam int RW = $clog2(RCT_CUTOFF + 1);

  logic [RW-1:0] run;
  logic [RW-1:0] run_nxt;
  logic          last_bit;

  // Run length including the bit being sampled now.
  always_comb begin
    run_nxt = RW'(1);
    if (run != '0 && trng_bit == last_bit) begin
      run_nxt = run + RW'(1);
    end
  end

  assign health_trip = (state == COLLECT) && granted_valid &&
                       (run_nxt >= RW'(RCT_CUTOFF));
  assign health_fail = (state == FAIL);

  // Repetition tracker: restarts at each grant, follows collected bits.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      run      <= '0;
      last_bit <= 1'b0;
    end else if (state == IDLE && |req_valid) begin
      run      <= '0;
      last_bit <= 1'b0;
    end else if (state == COLLECT && granted_valid) begin
      run      <= run_nxt;
      last_bit <= trng_bit;
    end
  end
`else
  assign health_trip = 1'b0;
  assign health_fail = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rdata     = '0;
    trng_req  = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) state_nxt = COLLECT;
      end
      COLLECT: begin
        trng_req = 1'b1;
        if (!granted_valid) begin
          state_nxt = IDLE;
        end else if (health_trip) begin
          state_nxt = FAIL;
        end else if (last_sample) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        req_ready[grant_q] = 1'b1;
        rdata              = word;
        state_nxt          = IDLE;
      end
      FAIL: begin
        state_nxt = FAIL;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Grant latch, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant_q <= 1'b0;
      word    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_q <= arb_grant;
            word    <= '0;
            cnt     <= '0;
          end
        end
        COLLECT: begin
          if (!granted_valid) begin
            word <= '0;
            cnt  <= '0;
          end else begin
            word <= {word[WIDTH-2:0], trng_bit};
            cnt  <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
